baccarat_table_seq: RTL and testbench

//  Multi-seat successor to the single-hand baccarat dealing FSM. Sequences card loads for
//  N_SEATS player hands against one shared dealer hand, applies the third-card rules, and

---
 rtl/baccarat_pkg.sv | 59 +++++
 rtl/baccarat_tally.sv | 31 +++
 rtl/baccarat_table_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_baccarat_table_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and card/score helpers for the multi-seat baccarat table sequencer.
package baccarat_pkg;

  localparam int CTR_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAL1  = 3'd1,
    S_DEAL2  = 3'd2,
    S_CHECK  = 3'd3,
    S_DRAW3  = 3'd4,
    S_DDEC   = 3'd5,
    S_DC3    = 3'd6,
    S_RESULT = 3'd7
  } state_t;

  // Out-of-range scores from the datapath behave as a 9.
  function automatic logic [3:0] sat9(input logic [3:0] s);
    if (s > 4'd9) begin
      return 4'd9;
    end else begin
      return s;
    end
  endfunction

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    if (rank >= 4'd10) begin
      return 4'd0;
    end else begin
      return rank;
    end
  endfunction

  function automatic logic is_natural(input logic [3:0] s);
    return (sat9(s) >= 4'd8);
  endfunction

  function automatic logic dealer_draws(input logic [3:0] dscore, input logic [3:0] v,
                                        input logic seat0_drew);
    logic [3:0] d;
    logic       r;
    d = sat9(dscore);
    r = 1'b0;
    if (!seat0_drew) begin
      r = (d <= 4'd5);
    end else begin
      case (d)
        4'd0, 4'd1, 4'd2: r = 1'b1;
        4'd3:             r = (v != 4'd8);
        4'd4:             r = (v >= 4'd2) && (v <= 4'd7);
        4'd5:             r = (v >= 4'd4) && (v <= 4'd7);
        4'd6:             r = (v >= 4'd6) && (v <= 4'd7);
        default:          r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/baccarat_tally.sv
// Saturating up-counter used for the round and per-seat win tallies.
module baccarat_tally
  import baccarat_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         slow_clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/baccarat_table_seq.sv
// Multi-seat baccarat dealing sequencer: card-load strobes, third-card rules,
// per-seat result lights and saturating tallies.
module baccarat_table_seq
  import baccarat_pkg::*;
#(
  parameter int N_SEATS = 2,
  parameter int TALLY_W = 8
) (
  input  logic                         slow_clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [4*N_SEATS-1:0]         pscore,
  input  logic [3:0]                   dscore,
  input  logic [4*N_SEATS-1:0]         pcard3,
  output logic [3*N_SEATS-1:0]         load_pcard,
  output logic [2:0]                   load_dcard,
  output logic                         busy,
  output logic                         done,
  output logic [N_SEATS-1:0]           player_win_light,
  output logic [N_SEATS-1:0]           dealer_win_light,
  output logic [TALLY_W-1:0]           round_count,
  output logic [TALLY_W*N_SEATS-1:0]   seat_wins
);

  localparam logic [CTR_W-1:0] DEALER_CTR = CTR_W'(N_SEATS);

  state_t                 state_r, state_s;
  logic [CTR_W-1:0]       ctr_r, ctr_s;
  logic [N_SEATS-1:0]     mask_r, mask_s;

  logic [N_SEATS-1:0]     draw_s, pl_s, dl_s, win_s;
  logic                   natural_s;
  logic [CTR_W-1:0]       first_idx_s, next_idx_s;
  logic                   next_found_s, cur_marked_s;
  logic [3*N_SEATS-1:0]   pstrobe_s;
  logic [2:0]             dstrobe_s;
  logic                   tally_inc_s;
  logic                   pcard3_unused_s;

  logic [3*N_SEATS-1:0]   load_pcard_r;
  logic [2:0]             load_dcard_r;
  logic                   busy_r, done_r;
  logic [N_SEATS-1:0]     pl_r, dl_r;

  // Only seat 0's third card feeds the dealer rule.
  assign pcard3_unused_s = ^pcard3;

  // Per-seat draw eligibility and outcome against the dealer.
  always_comb begin
    draw_s    = {N_SEATS{1'b0}};
    pl_s      = {N_SEATS{1'b0}};
    dl_s      = {N_SEATS{1'b0}};
    win_s     = {N_SEATS{1'b0}};
    natural_s = is_natural(dscore) || is_natural(pscore[3:0]);
    for (int i = 0; i < N_SEATS; i++) begin
      draw_s[i] = (sat9(pscore[4*i +: 4]) <= 4'd5);
      pl_s[i]   = (sat9(pscore[4*i +: 4]) >= sat9(dscore));
      dl_s[i]   = (sat9(pscore[4*i +: 4]) <= sat9(dscore));
      win_s[i]  = (sat9(pscore[4*i +: 4]) >  sat9(dscore));
    end
  end

  // Lowest marked seat, next marked seat above ctr, and whether ctr is marked.
  always_comb begin
    first_idx_s  = {CTR_W{1'b0}};
    next_idx_s   = {CTR_W{1'b0}};
    next_found_s = 1'b0;
    cur_marked_s = 1'b0;
    for (int i = N_SEATS - 1; i >= 0; i--) begin
      first_idx_s  = draw_s[i] ? CTR_W'(i) : first_idx_s;
      next_found_s = (mask_r[i] && (CTR_W'(i) > ctr_r)) ? 1'b1 : next_found_s;
      next_idx_s   = (mask_r[i] && (CTR_W'(i) > ctr_r)) ? CTR_W'(i) : next_idx_s;
      cur_marked_s = (ctr_r == CTR_W'(i)) ? mask_r[i] : cur_marked_s;
    end
  end

  // Next-state logic for the round sequencer.
  always_comb begin
    state_s = state_r;
    ctr_s   = ctr_r;
    mask_s  = mask_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_DEAL1;
          ctr_s   = {CTR_W{1'b0}};
          mask_s  = {N_SEATS{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DEAL1, S_DEAL2: begin
        if (ctr_r < DEALER_CTR) begin
          ctr_s = ctr_r + CTR_W'(1);
        end else if (ctr_r == DEALER_CTR) begin
          ctr_s   = {CTR_W{1'b0}};
          state_s = (state_r == S_DEAL1) ? S_DEAL2 : S_CHECK;
        end else begin
          ctr_s   = {CTR_W{1'b0}};
          state_s = S_IDLE;
        end
      end
      S_CHECK: begin
        ctr_s = {CTR_W{1'b0}};
        if (natural_s) begin
          mask_s  = {N_SEATS{1'b0}};
          state_s = S_RESULT;
        end else if (draw_s == {N_SEATS{1'b0}}) begin
          mask_s  = draw_s;
          state_s = S_DDEC;
        end else begin
          mask_s  = draw_s;
          ctr_s   = first_idx_s;
          state_s = S_DRAW3;
        end
      end
      S_DRAW3: begin
        if ((ctr_r < DEALER_CTR) && cur_marked_s) begin
          if (next_found_s) begin
            ctr_s = next_idx_s;
          end else begin
            ctr_s   = {CTR_W{1'b0}};
            state_s = S_DDEC;
          end
        end else begin
          ctr_s   = {CTR_W{1'b0}};
          state_s = S_IDLE;
        end
      end
      S_DDEC:   state_s = dealer_draws(dscore, card_value(pcard3[3:0]), mask_r[0]) ? S_DC3 : S_RESULT;
      S_DC3:    state_s = S_RESULT;
      S_RESULT: begin
        state_s = S_IDLE;
        ctr_s   = {CTR_W{1'b0}};
      end
      default: begin
        state_s = S_IDLE;
        ctr_s   = {CTR_W{1'b0}};
      end
    endcase
  end

  // Strobes for the cycle about to start, decoded from next state so they register cleanly.
  always_comb begin
    pstrobe_s = {(3*N_SEATS){1'b0}};
    dstrobe_s = 3'b000;
    case (state_s)
      S_DEAL1, S_DEAL2: begin
        for (int i = 0; i < N_SEATS; i++) begin
          pstrobe_s[3*i]     = (state_s == S_DEAL1) && (ctr_s == CTR_W'(i));
          pstrobe_s[3*i + 1] = (state_s == S_DEAL2) && (ctr_s == CTR_W'(i));
        end
        dstrobe_s[0] = (state_s == S_DEAL1) && (ctr_s == DEALER_CTR);
        dstrobe_s[1] = (state_s == S_DEAL2) && (ctr_s == DEALER_CTR);
      end
      S_DRAW3: begin
        for (int i = 0; i < N_SEATS; i++) begin
          pstrobe_s[3*i + 2] = (ctr_s == CTR_W'(i));
        end
      end
      S_DC3:   dstrobe_s = 3'b100;
      default: begin
        pstrobe_s = {(3*N_SEATS){1'b0}};
        dstrobe_s = 3'b000;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      ctr_r   <= {CTR_W{1'b0}};
      mask_r  <= {N_SEATS{1'b0}};
    end else begin
      state_r <= state_s;
      ctr_r   <= ctr_s;
      mask_r  <= mask_s;
    end
  end

  // Output registers; lights capture final scores as RESULT closes.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      load_pcard_r <= {(3*N_SEATS){1'b0}};
      load_dcard_r <= 3'b000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pl_r         <= {N_SEATS{1'b0}};
      dl_r         <= {N_SEATS{1'b0}};
    end else begin
      load_pcard_r <= pstrobe_s;
      load_dcard_r <= dstrobe_s;
      busy_r       <= (state_s != S_IDLE);
      done_r       <= (state_r == S_RESULT);
      if (state_r == S_RESULT) begin
        pl_r <= pl_s;
        dl_r <= dl_s;
      end else if ((state_r == S_IDLE) && start) begin
        pl_r <= {N_SEATS{1'b0}};
        dl_r <= {N_SEATS{1'b0}};
      end else begin
        pl_r <= pl_r;
        dl_r <= dl_r;
      end
    end
  end

  assign tally_inc_s = (state_r == S_RESULT);

  baccarat_tally #(.W(TALLY_W)) u_round_tally (
    .slow_clock (slow_clock),
    .reset      (reset),
    .clr        (1'b0),
    .inc        (tally_inc_s),
    .count      (round_count)
  );

  for (genvar g = 0; g < N_SEATS; g++) begin : g_seat
    baccarat_tally #(.W(TALLY_W)) u_win_tally (
      .slow_clock (slow_clock),
      .reset      (reset),
      .clr        (1'b0),
      .inc        (tally_inc_s && win_s[g]),
      .count      (seat_wins[g*TALLY_W +: TALLY_W])
    );
  end

  assign load_pcard       = load_pcard_r;
  assign load_dcard       = load_dcard_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign player_win_light = pl_r;
  assign dealer_win_light = dl_r;

endmodule

// File: tb/tb_baccarat_table_seq.sv
// Scoreboard bench for baccarat_table_seq with two seats and a small card-datapath model.
module tb_baccarat_table_seq;

  logic        slow_clock, reset, start;
  logic [7:0]  pscore, pcard3;
  logic [3:0]  dscore;
  logic [5:0]  load_pcard;
  logic [2:0]  load_dcard;
  logic        busy, done;
  logic [1:0]  player_win_light, dealer_win_light;
  logic [7:0]  round_count;
  logic [15:0] seat_wins;

  typedef struct {
    logic [1:0] pl;
    logic [1:0] dl;
    int         lat;
    logic [7:0] rc;
    logic [7:0] w0;
    logic [7:0] w1;
  } exp_t;

  exp_t       exp_q[$];
  int         strobe_q[$];
  exp_t       mon_e;
  int         n_vec, n_err, done_cnt, lat_cnt, mon_j, target;
  logic [8:0] mon_sv;
  logic [2:0] p3_seen;
  logic [3:0] pre_p0, pre_p1, pre_d, post_p0, post_p1, post_d;
  logic [7:0] m_rc, m_w0, m_w1;

  baccarat_table_seq #(.N_SEATS(2), .TALLY_W(8)) dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .start            (start),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard       (load_pcard),
    .load_dcard       (load_dcard),
    .busy             (busy),
    .done             (done),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .round_count      (round_count),
    .seat_wins        (seat_wins)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // Datapath model: a seat's score switches to its post-draw value once its third card loads.
  assign pscore = {p3_seen[1] ? post_p1 : pre_p1, p3_seen[0] ? post_p0 : pre_p0};
  assign dscore = p3_seen[2] ? post_d : pre_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_sat(input logic [3:0] s);
    return (s > 4'd9) ? 9 : int'(s);
  endfunction

  function automatic int m_val(input logic [3:0] r);
    return (r >= 4'd10) ? 0 : int'(r);
  endfunction

  function automatic logic m_dealer(input int sd, input int v, input logic d0);
    if (!d0) return (sd <= 5);
    return (sd < 3) || (sd == 3 && v != 8) || (sd == 4 && v >= 2 && v <= 7) ||
           (sd == 5 && v >= 4 && v <= 7) || (sd == 6 && v >= 6 && v <= 7);
  endfunction

  // Push the expected strobe sequence and result, then pulse start.
  task automatic launch(input logic [3:0] p0, p1, d, r0, r1, q0, q1, qd);
    logic       nat, bd;
    logic [1:0] drew;
    int         f0, f1, fd;
    exp_t       e;
    strobe_q.push_back(0); strobe_q.push_back(3); strobe_q.push_back(6);
    strobe_q.push_back(1); strobe_q.push_back(4); strobe_q.push_back(7);
    nat  = (m_sat(d) >= 8) || (m_sat(p0) >= 8);
    drew = 2'b00;
    bd   = 1'b0;
    if (!nat) begin
      drew[0] = (m_sat(p0) <= 5);
      drew[1] = (m_sat(p1) <= 5);
      if (drew[0]) strobe_q.push_back(2);
      if (drew[1]) strobe_q.push_back(5);
      bd = m_dealer(m_sat(d), m_val(r0), drew[0]);
      if (bd) strobe_q.push_back(8);
    end
    f0 = m_sat(drew[0] ? q0 : p0);
    f1 = m_sat(drew[1] ? q1 : p1);
    fd = m_sat(bd ? qd : d);
    e.pl  = {f1 >= fd, f0 >= fd};
    e.dl  = {f1 <= fd, f0 <= fd};
    e.lat = 8 + (nat ? 0 : (int'(drew[0]) + int'(drew[1]) + 1 + int'(bd)));
    if (m_rc != 8'hFF) m_rc = m_rc + 8'd1;
    if (f0 > fd && m_w0 != 8'hFF) m_w0 = m_w0 + 8'd1;
    if (f1 > fd && m_w1 != 8'hFF) m_w1 = m_w1 + 8'd1;
    e.rc = m_rc; e.w0 = m_w0; e.w1 = m_w1;
    exp_q.push_back(e);
    @(negedge slow_clock);
    pre_p0 = p0; pre_p1 = p1; pre_d = d;
    post_p0 = q0; post_p1 = q1; post_d = qd;
    pcard3 = {r1, r0};
    target = done_cnt + 1;
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < target && n < 64) begin
      @(negedge slow_clock);
      n++;
    end
    @(negedge slow_clock);
    check_eq("done_seen", done_cnt, target);
  endtask

  task automatic run_round(input logic [3:0] p0, p1, d, r0, r1, q0, q1, qd);
    launch(p0, p1, d, r0, r1, q0, q1, qd);
    wait_done();
  endtask

  // Monitor: strobe order/one-hot, datapath model update, and result scoreboard.
  always @(negedge slow_clock) begin
    if (reset) begin
      lat_cnt = 0;
    end else begin
      mon_sv = {load_dcard, load_pcard};
      if (mon_sv != 9'd0) begin
        check_eq("onehot", $countones(mon_sv), 1);
        mon_j = 0;
        for (int j = 8; j >= 0; j--) if (mon_sv[j]) mon_j = j;
        if (strobe_q.size() == 0) check_eq("extra_strobe", mon_j, 99);
        else check_eq("strobe_order", mon_j, strobe_q.pop_front());
        if (mon_sv[0]) p3_seen = 3'b000;
        if (mon_sv[2]) p3_seen[0] = 1'b1;
        if (mon_sv[5]) p3_seen[1] = 1'b1;
        if (mon_sv[8]) p3_seen[2] = 1'b1;
      end
      if (busy) lat_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("player_light", player_win_light, mon_e.pl);
          check_eq("dealer_light", dealer_win_light, mon_e.dl);
          check_eq("latency", lat_cnt, mon_e.lat);
          check_eq("round_count", round_count, mon_e.rc);
          check_eq("seat0_wins", seat_wins[7:0], mon_e.w0);
          check_eq("seat1_wins", seat_wins[15:8], mon_e.w1);
        end
        done_cnt++;
        lat_cnt = 0;
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; done_cnt = 0; lat_cnt = 0; target = 0;
    reset = 1'b1; start = 1'b0; pcard3 = 8'd0; p3_seen = 3'b000;
    pre_p0 = 4'd0; pre_p1 = 4'd0; pre_d = 4'd0;
    post_p0 = 4'd0; post_p1 = 4'd0; post_d = 4'd0;
    m_rc = 8'd0; m_w0 = 8'd0; m_w1 = 8'd0;
    repeat (2) @(negedge slow_clock);
    check_eq("rst_load_pcard", load_pcard, 0);
    check_eq("rst_load_dcard", load_dcard, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_lights", {player_win_light, dealer_win_light}, 0);
    check_eq("rst_counts", {round_count, seat_wins}, 0);
    reset = 1'b0;
    @(negedge slow_clock);
    check_eq("idle_busy", busy, 0);

    // Seat 0 natural: no third cards.
    run_round(4'd8, 4'd2, 4'd3, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0);

    // Reset during DEAL2 aborts the round at once.
    launch(4'd4, 4'd6, 4'd5, 4'd12, 4'd1, 4'd4, 4'd7, 4'd5);
    repeat (4) @(negedge slow_clock);
    reset = 1'b1;
    #1;
    check_eq("abort_strobes", {load_dcard, load_pcard}, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_lights", {player_win_light, dealer_win_light}, 0);
    check_eq("abort_counts", {round_count, seat_wins}, 0);
    strobe_q.delete();
    exp_q.delete();
    m_rc = 8'd0; m_w0 = 8'd0; m_w1 = 8'd0;
    @(negedge slow_clock);
    reset = 1'b0;
    repeat (6) begin
      @(negedge slow_clock);
      check_eq("abort_idle_busy", busy, 0);
    end

    // Seat 0 draws a face card, dealer on 5 stands.
    run_round(4'd4, 4'd6, 4'd5, 4'd12, 4'd1, 4'd4, 4'd7, 4'd5);
    // Both seats draw, dealer on 3 stands against an 8.
    run_round(4'd2, 4'd3, 4'd3, 4'd8, 4'd5, 4'd0, 4'd8, 4'd3);
    // Seat 0 stands, seat 1 draws, dealer on 4 draws.
    run_round(4'd7, 4'd2, 4'd4, 4'd3, 4'd9, 4'd7, 4'd1, 4'd9);
    // Nobody draws: 7-7 tie on seat 0.
    run_round(4'd7, 4'd6, 4'd7, 4'd2, 4'd2, 4'd7, 4'd6, 4'd7);
    // 5 vs 5 ties after both seats draw tens.
    run_round(4'd5, 4'd5, 4'd5, 4'd13, 4'd10, 4'd5, 4'd5, 4'd5);
    // Out-of-range seat score behaves as a natural 9.
    run_round(4'd11, 4'd3, 4'd9, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
    // Dealer on 6 draws against a 6.
    run_round(4'd1, 4'd9, 4'd6, 4'd6, 4'd4, 4'd7, 4'd9, 4'd9);

    for (int k = 0; k < 10; k++) begin
      logic [3:0] a, b, c, r0, r1, x;
      a  = 4'($urandom_range(0, 9));
      b  = 4'($urandom_range(0, 9));
      c  = 4'($urandom_range(0, 9));
      r0 = 4'($urandom_range(1, 13));
      r1 = 4'($urandom_range(1, 13));
      x  = 4'($urandom_range(0, 9));
      run_round(a, b, c, r0, r1, 4'((int'(a) + m_val(r0)) % 10),
                4'((int'(b) + m_val(r1)) % 10), 4'((int'(c) + int'(x)) % 10));
    end

    // Drive both win tallies and the round counter into saturation.
    for (int k = 0; k < 260; k++) begin
      run_round(4'd9, 4'd7, 4'd3, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
    end
    check_eq("sat_seat0", seat_wins[7:0], 255);
    check_eq("sat_seat1", seat_wins[15:8], 255);
    check_eq("sat_rounds", round_count, 255);
    check_eq("strobe_q_empty", strobe_q.size(), 0);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
